bin2gray: RTL and testbench
===========================

BIN2GRAY -- requirements
Module: bin2gray

Interface
REQ-001 Parameter WIDTH, default 4, meaning bit width of all binary/Gray data ports; SHALL support any WIDTH >= 1.
REQ-002 clk  input  1  sole clock; all registers update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 bin  input  WIDTH  binary value to encode.
REQ-005 gray  output  WIDTH  combinational Gray encoding of bin.
REQ-006 in_valid  input  1  qualifies bin for capture into the registered path.
REQ-007 gray_q  output  WIDTH  registered Gray encoding of the last valid bin.
REQ-008 out_valid  output  1  high for one cycle when gray_q holds a newly captured value.
REQ-009 gray_adj  output  1  registered flag; high when the new gray_q differs from the previous valid gray_q in exactly one bit.
REQ-010 gray_in  input  WIDTH  Gray value to decode.
REQ-011 bin_out  output  WIDTH  combinational binary decoding of gray_in.

Function
REQ-012 gray SHALL equal bin XOR (bin >> 1) with zero fill at MSB, i.e. gray[WIDTH-1]=bin[WIDTH-1] and gray[i]=bin[i+1]^bin[i]; zero latency, no dependence on clk or rst.
REQ-013 bin_out SHALL decode gray_in: bin_out[WIDTH-1]=gray_in[WIDTH-1], bin_out[i]=bin_out[i+1]^gray_in[i]; zero latency, no dependence on clk or rst.
REQ-014 On a rising clk edge with rst low and in_valid high: gray_q SHALL load the encoding of bin (one-cycle latency); out_valid SHALL be 1 in the following cycle.
REQ-015 On a rising clk edge with rst low and in_valid low: gray_q SHALL hold; out_valid SHALL be 0; gray_adj SHALL hold.
REQ-016 gray_adj SHALL be computed at capture as popcount(new gray XOR previous gray_q) == 1, updated only on captures with in_valid high.
REQ-017 The first capture after reset SHALL set gray_adj to 0 (no prior value to compare).
REQ-018 Capturing the same bin twice SHALL yield gray_adj = 0 (zero bits differ).
REQ-019 Wrap-around: consecutive captures of all-ones then all-zeros binary SHALL yield gray_adj = 1 (Gray codes differ only in MSB).
REQ-020 WIDTH = 1: gray SHALL equal bin, bin_out SHALL equal gray_in; any change in the value SHALL give gray_adj = 1.
REQ-021 Encode and decode paths SHALL be independent; bin_out of gray SHALL equal bin for all values (round trip identity).

Reset
REQ-022 On a rising clk edge with rst high: gray_q SHALL become 0, out_valid 0, gray_adj 0, and the "no previous value" state SHALL be set; in_valid is ignored that cycle.
REQ-023 Reset asserted mid-stream SHALL discard the pending/previous value; combinational outputs gray and bin_out SHALL be unaffected by rst.

Verification
REQ-024 WIDTH=4, bin=4'b1100 -> gray=4'b1010 immediately; bin=4'b0010 -> gray=4'b0011 immediately.
REQ-025 gray_in=4'b1010 -> bin_out=4'b1100; sweep all 16 values of bin with gray_in=gray -> bin_out==bin every time.
REQ-026 After rst, capture bin=4'b0111 then 4'b1000 on consecutive cycles -> gray_q=4'b0100 with out_valid=1, gray_adj=0; then gray_q=4'b1100, out_valid=1, gray_adj=1.
REQ-027 Capture 4'b1100 then 4'b0010 -> gray_q 4'b1010 then 4'b0011, gray_adj=0 (two bits differ); capture 4'b1111 then 4'b0000 -> gray_adj=1.
REQ-028 in_valid low for 3 cycles after a capture -> gray_q and gray_adj hold, out_valid=0; rst high one cycle mid-stream -> gray_q=0, out_valid=0, gray_adj=0, next capture gives gray_adj=0.

Source files
------------

// File: rtl/bin2gray.sv
// rtl/bin2gray.sv - binary/Gray encoder, registered Gray capture and Gray decoder
//
// Ports:
//   clk       rising-edge clock for the registered path
//   rst       synchronous active-high reset of the registered path
//   bin       binary value to encode
//   gray      combinational Gray encoding of bin
//   in_valid  qualifies bin for capture into gray_q
//   gray_q    registered Gray encoding of the last valid bin
//   out_valid one-cycle pulse when gray_q holds a newly captured value
//   gray_adj  registered flag: new gray_q differs from the previous one in exactly one bit
//   gray_in   Gray value to decode
//   bin_out   combinational binary decoding of gray_in
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    output logic             gray_adj,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    logic [WIDTH-1:0] diff;
    logic             one_bit_diff;
    logic             have_prev;

    // Encode: each bit is the XOR of itself and its upper neighbour; MSB passes through.
    assign gray = bin ^ (bin >> 1);

    // Decode: binary bit i is the parity of Gray bits i..MSB.
    always_comb begin
        bin_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_out[i] = ^(gray_in >> i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign diff         = gray ^ gray_q;
    assign one_bit_diff = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            gray_q    <= '0;
            out_valid <= 1'b0;
            gray_adj  <= 1'b0;
            have_prev <= 1'b0;
        end else if (in_valid) begin
            gray_q    <= gray;
            out_valid <= 1'b1;
            // With no earlier capture there is nothing to compare against.
            gray_adj  <= have_prev && one_bit_diff;
            have_prev <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bin2gray.sv
// tb/tb_bin2gray.sv - self-checking bench for bin2gray
module tb_bin2gray;

    localparam int W = 4;
    localparam int N = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] bin = '0;
    logic [W-1:0] gray;
    logic         in_valid = 1'b0;
    logic [W-1:0] gray_q;
    logic         out_valid;
    logic         gray_adj;
    logic [W-1:0] gray_in = '0;
    logic [W-1:0] bin_out;

    int compared   = 0;
    int mismatched = 0;
    bit model_on   = 1'b0;

    bin2gray #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bin      (bin),
        .gray     (gray),
        .in_valid (in_valid),
        .gray_q   (gray_q),
        .out_valid(out_valid),
        .gray_adj (gray_adj),
        .gray_in  (gray_in),
        .bin_out  (bin_out)
    );

    always #5 clk = ~clk;

    // Reference Gray sequence built by reflection: the second half of an
    // (n+1)-bit code is the n-bit code reversed with bit n set.
    logic [W-1:0] enc_tab [N];

    function automatic logic [W-1:0] dec_ref(input logic [W-1:0] g);
        for (int k = 0; k < N; k++) begin
            if (enc_tab[k] == g) return W'(k);
        end
        return 'x;
    endfunction

    // Behavioural model of the registered path.
    logic [W-1:0] m_q    = '0;
    bit           m_v    = 1'b0;
    bit           m_adj  = 1'b0;
    bit           m_have = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0] ng;
        if (rst) begin
            m_q = '0; m_v = 1'b0; m_adj = 1'b0; m_have = 1'b0;
        end else if (in_valid) begin
            ng     = enc_tab[bin];
            m_adj  = m_have && ($countones(ng ^ m_q) == 1);
            m_q    = ng;
            m_v    = 1'b1;
            m_have = 1'b1;
        end else begin
            m_v = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("gray",      gray,      enc_tab[bin]);
            chk("bin_out",   bin_out,   dec_ref(gray_in));
            chk("gray_q",    gray_q,    m_q);
            chk("out_valid", W'(out_valid), W'(m_v));
            chk("gray_adj",  W'(gray_adj),  W'(m_adj));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [W-1:0] b);
        bin = b; in_valid = 1'b1;
        tick();
    endtask

    initial begin
        logic [W-1:0] prev_b;

        enc_tab[0] = '0;
        for (int n = 0; n < W; n++) begin
            for (int k = 0; k < (1 << n); k++) begin
                enc_tab[(1 << n) + k] = enc_tab[(1 << n) - 1 - k] | W'(1 << n);
            end
        end

        // Literal pins on the reference table itself.
        chk("tab_1100", enc_tab[12], 4'b1010);
        chk("tab_0010", enc_tab[2],  4'b0011);
        chk("dec_1010", dec_ref(4'b1010), 4'b1100);

        tick();
        tick();
        model_on = 1'b1;
        chk("rst_gray_q",    gray_q,         '0);
        chk("rst_out_valid", W'(out_valid),  '0);
        chk("rst_gray_adj",  W'(gray_adj),   '0);
        rst = 1'b0;

        bin = 4'b1100; #1;
        chk("enc_1100", gray, 4'b1010);
        bin = 4'b0010; #1;
        chk("enc_0010", gray, 4'b0011);
        gray_in = 4'b1010; #1;
        chk("dec_1010_dut", bin_out, 4'b1100);

        for (int k = 0; k < N; k++) begin
            bin = W'(k); #1;
            gray_in = gray; #1;
            chk("round_trip", bin_out, W'(k));
        end

        // First capture after reset, then a one-bit step.
        capture(4'b0111);
        chk("c1_gray_q", gray_q, 4'b0100);
        chk("c1_valid",  W'(out_valid), 4'd1);
        chk("c1_adj",    W'(gray_adj),  4'd0);
        capture(4'b1000);
        chk("c2_gray_q", gray_q, 4'b1100);
        chk("c2_valid",  W'(out_valid), 4'd1);
        chk("c2_adj",    W'(gray_adj),  4'd1);

        capture(4'b1100);
        chk("c3_gray_q", gray_q, 4'b1010);
        capture(4'b0010);
        chk("c4_gray_q", gray_q, 4'b0011);
        chk("c4_adj",    W'(gray_adj), 4'd0);
        capture(4'b0010);
        chk("same_adj",  W'(gray_adj), 4'd0);
        capture(4'b1111);
        capture(4'b0000);
        chk("wrap_adj",  W'(gray_adj), 4'd1);

        capture(4'b0001);
        chk("c5_adj", W'(gray_adj), 4'd1);
        in_valid = 1'b0;
        bin = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_gray_q", gray_q, 4'b0001);
            chk("hold_adj",    W'(gray_adj),  4'd1);
            chk("hold_valid",  W'(out_valid), 4'd0);
        end

        rst = 1'b1; in_valid = 1'b1; bin = 4'b0110;
        #1;
        chk("rst_comb_gray", gray, 4'b0101);
        tick();
        chk("mid_rst_gray_q", gray_q, '0);
        chk("mid_rst_valid",  W'(out_valid), 4'd0);
        chk("mid_rst_adj",    W'(gray_adj),  4'd0);
        rst = 1'b0;
        capture(4'b0000);
        chk("post_rst_gray_q", gray_q, '0);
        chk("post_rst_valid",  W'(out_valid), 4'd1);
        chk("post_rst_adj",    W'(gray_adj),  4'd0);

        // Randomized traffic; neighbours of the previous value are favoured
        // so that single-bit Gray steps occur often.
        prev_b = '0;
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bin = prev_b + 1'b1;
                1:       bin = prev_b - 1'b1;
                2:       bin = prev_b;
                default: bin = W'($urandom);
            endcase
            gray_in = W'($urandom);
            if (in_valid) prev_b = bin;
            tick();
        end

        rst = 1'b0; in_valid = 1'b0;
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
